maxnet_vector_weight_mem: RTL and testbench

// - Parametrised weight/input store for the Maxnet datapath: holds an N x N IEEE-754 weight matrix and a

---
 rtl/maxnet_pkg.sv | 25 ++
 rtl/maxnet_vector_weight_mem_x_bank_pair.sv | 57 +++++
 rtl/maxnet_vector_weight_mem.sv | 116 +++++++++++
 tb/tb_maxnet_vector_weight_mem.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared constants, state encoding and width helper for the Maxnet weight/input store.
package maxnet_pkg;

  localparam int DEF_DATA_W = 32;

  localparam logic [31:0] FP_ONE     = 32'h3f800000;
  localparam logic [31:0] FP_NEG_ONE = 32'hbf800000;
  localparam logic [31:0] FP_0P2     = 32'h3e4ccccd;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Bits needed to index n entries; bounded loop so it stays a constant function.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (((n - 1) >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/maxnet_vector_weight_mem_x_bank_pair.sv
// Double-buffered X vector: writes land in the shadow bank, a swap flips which bank drives x_out.
module x_bank_pair
  import maxnet_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = DEF_DATA_W,
  localparam int AW    = clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                swap,
  input  logic                streaming,
  input  logic                stream_end,
  output logic [N*DATA_W-1:0] x_out
);

  localparam logic [AW:0] N_EXT = (AW+1)'(N);

  logic [DATA_W-1:0] bank [2][N];
  logic              active;
  logic              pending;
  logic              wr_ok;

  assign wr_ok = wr_en & ({1'b0, wr_addr} < N_EXT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          bank[b][i] <= '0;
        end
      end
      active  <= 1'b0;
      pending <= 1'b0;
    end else begin
      // Shadow is taken from the pre-edge active bit, so a write alongside a swap lands in the new active bank.
      if (wr_ok) bank[~active][wr_addr] <= wr_data;
      if (!streaming) begin
        pending <= 1'b0;
        if (swap) active <= ~active;
      end else if (stream_end) begin
        pending <= 1'b0;
        if (pending | swap) active <= ~active;
      end else if (swap) begin
        pending <= 1'b1;
      end
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_xout
    assign x_out[c*DATA_W +: DATA_W] = bank[active][c];
  end

endmodule

// File: rtl/maxnet_vector_weight_mem.sv
// Weight matrix plus X vector store that streams one weight row per beat to the Maxnet PE array.
module maxnet_vector_weight_mem
  import maxnet_pkg::*;
#(
  parameter int                N      = 4,
  parameter int                DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] DIAG_W = DATA_W'(FP_0P2),
  parameter logic [DATA_W-1:0] OFF_W  = DATA_W'(FP_NEG_ONE),
  localparam int               AW     = clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                x_wr_en,
  input  logic [AW-1:0]       x_wr_addr,
  input  logic [DATA_W-1:0]   x_wr_data,
  input  logic                x_swap,
  input  logic                w_wr_en,
  input  logic [AW-1:0]       w_wr_row,
  input  logic [AW-1:0]       w_wr_col,
  input  logic [DATA_W-1:0]   w_wr_data,
  input  logic                rd_start,
  input  logic                rd_ready,
  output logic                rd_valid,
  output logic [AW-1:0]       rd_row,
  output logic                rd_last,
  output logic [N*DATA_W-1:0] w_row_out,
  output logic [N*DATA_W-1:0] x_out,
  output logic                busy,
  output logic                done,
  output logic                w_wr_drop
);

  localparam logic [AW-1:0] LAST_ROW = AW'(N - 1);
  localparam logic [AW:0]   N_EXT    = (AW+1)'(N);

  state_t            state;
  logic [DATA_W-1:0] w_mem [N][N];
  logic              w_wr_ok;
  logic              stream_end;

  assign w_wr_ok = w_wr_en & (state == IDLE)
                 & ({1'b0, w_wr_row} < N_EXT) & ({1'b0, w_wr_col} < N_EXT);
  assign stream_end = (state == STREAM) & rd_ready & (rd_row == LAST_ROW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          w_mem[i][j] <= (i == j) ? DIAG_W : OFF_W;
        end
      end
    end else if (w_wr_ok) begin
      w_mem[w_wr_row][w_wr_col] <= w_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rd_valid  <= 1'b0;
      rd_row    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_wr_drop <= 1'b0;
    end else begin
      done      <= 1'b0;
      w_wr_drop <= w_wr_en & ~w_wr_ok;
      case (state)
        IDLE: begin
          if (rd_start) begin
            state    <= STREAM;
            rd_valid <= 1'b1;
            busy     <= 1'b1;
            rd_row   <= '0;
          end
        end
        STREAM: begin
          if (rd_ready) begin
            if (rd_row == LAST_ROW) begin
              state    <= IDLE;
              rd_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              rd_row   <= '0;
            end else begin
              rd_row <= rd_row + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_last = rd_valid & (rd_row == LAST_ROW);

  for (genvar c = 0; c < N; c++) begin : g_wrow
    assign w_row_out[c*DATA_W +: DATA_W] = w_mem[rd_row][c];
  end

  x_bank_pair #(
    .N      (N),
    .DATA_W (DATA_W)
  ) u_x_bank_pair (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (x_wr_en),
    .wr_addr    (x_wr_addr),
    .wr_data    (x_wr_data),
    .swap       (x_swap),
    .streaming  (state == STREAM),
    .stream_end (stream_end),
    .x_out      (x_out)
  );

endmodule

// File: tb/tb_maxnet_vector_weight_mem.sv
// Directed bench for maxnet_vector_weight_mem: stall table plus hand-written stream, swap, write and reset sequences.
module tb_maxnet_vector_weight_mem;
  import maxnet_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         x_wr_en, x_swap, w_wr_en, rd_start, rd_ready;
  logic [1:0]   x_wr_addr, w_wr_row, w_wr_col;
  logic [31:0]  x_wr_data, w_wr_data;
  logic         rd_valid, rd_last, busy, done, w_wr_drop;
  logic [1:0]   rd_row;
  logic [127:0] w_row_out, x_out;

  logic         d5_x_wr_en, d5_x_swap, d5_w_wr_en, d5_rd_start, d5_rd_ready;
  logic [2:0]   d5_x_wr_addr, d5_w_wr_row, d5_w_wr_col;
  logic [31:0]  d5_x_wr_data, d5_w_wr_data;
  logic         d5_rd_valid, d5_rd_last, d5_busy, d5_done, d5_w_wr_drop;
  logic [2:0]   d5_rd_row;
  logic [159:0] d5_w_row_out, d5_x_out;

  always #5 clk = ~clk;

  maxnet_vector_weight_mem #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr), .x_wr_data(x_wr_data), .x_swap(x_swap),
    .w_wr_en(w_wr_en), .w_wr_row(w_wr_row), .w_wr_col(w_wr_col), .w_wr_data(w_wr_data),
    .rd_start(rd_start), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_row(rd_row),
    .rd_last(rd_last), .w_row_out(w_row_out), .x_out(x_out), .busy(busy), .done(done),
    .w_wr_drop(w_wr_drop)
  );

  // Non-power-of-two instance so out-of-range indices are representable.
  maxnet_vector_weight_mem #(.N(5)) dut5 (
    .clk(clk), .rst(rst),
    .x_wr_en(d5_x_wr_en), .x_wr_addr(d5_x_wr_addr), .x_wr_data(d5_x_wr_data), .x_swap(d5_x_swap),
    .w_wr_en(d5_w_wr_en), .w_wr_row(d5_w_wr_row), .w_wr_col(d5_w_wr_col), .w_wr_data(d5_w_wr_data),
    .rd_start(d5_rd_start), .rd_ready(d5_rd_ready), .rd_valid(d5_rd_valid), .rd_row(d5_rd_row),
    .rd_last(d5_rd_last), .w_row_out(d5_w_row_out), .x_out(d5_x_out), .busy(d5_busy), .done(d5_done),
    .w_wr_drop(d5_w_wr_drop)
  );

  typedef struct {
    logic       ready;
    logic       v;
    logic [1:0] row;
    logic       last;
    logic       dn;
    logic       bz;
  } stall_vec_t;

  stall_vec_t  sv [11];
  logic [31:0] wm [N][N];
  logic [31:0] xm [N];
  logic [31:0] xs [N];
  logic [31:0] x1 [N];
  logic [31:0] x2 [N];
  int          nvec = 0;
  int          nerr = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] wrow(input int r);
    logic [127:0] v;
    for (int c = 0; c < N; c++) v[c*32 +: 32] = wm[r][c];
    return v;
  endfunction

  function automatic logic [127:0] xvec();
    logic [127:0] v;
    for (int c = 0; c < N; c++) v[c*32 +: 32] = xm[c];
    return v;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) wm[i][j] = (i == j) ? FP_0P2 : FP_NEG_ONE;
      xm[i] = '0;
      xs[i] = '0;
    end
  endtask

  task automatic run_stream(input string tag);
    rd_start = 1'b1;
    rd_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    w_wr_en  = 1'b0;
    for (int r = 0; r < N; r++) begin
      chk($sformatf("%s r%0d valid", tag, r), 128'(rd_valid), 128'(1));
      chk($sformatf("%s r%0d row", tag, r), 128'(rd_row), 128'(r));
      chk($sformatf("%s r%0d last", tag, r), 128'(rd_last), 128'(r == N - 1));
      chk($sformatf("%s r%0d busy", tag, r), 128'(busy), 128'(1));
      chk($sformatf("%s r%0d done", tag, r), 128'(done), 128'(0));
      chk($sformatf("%s r%0d wrow", tag, r), w_row_out, wrow(r));
      chk($sformatf("%s r%0d xout", tag, r), x_out, xvec());
      tick();
    end
    chk({tag, " done"}, 128'(done), 128'(1));
    chk({tag, " end valid"}, 128'(rd_valid), 128'(0));
    chk({tag, " end busy"}, 128'(busy), 128'(0));
    chk({tag, " end row"}, 128'(rd_row), 128'(0));
    tick();
    chk({tag, " done pulse"}, 128'(done), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int xfers;
    sv[0]  = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1};
    sv[1]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1};
    sv[2]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1};
    sv[3]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1};
    sv[4]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1};
    sv[5]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1};
    sv[6]  = '{1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1};
    sv[7]  = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1};
    sv[8]  = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1};
    sv[9]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
    sv[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    x1 = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000};
    x2 = '{32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000};

    rst = 1'b0;
    {x_wr_en, x_swap, w_wr_en, rd_start, rd_ready} = '0;
    {x_wr_addr, w_wr_row, w_wr_col, x_wr_data, w_wr_data} = '0;
    {d5_x_wr_en, d5_x_swap, d5_w_wr_en, d5_rd_start, d5_rd_ready} = '0;
    {d5_x_wr_addr, d5_w_wr_row, d5_w_wr_col, d5_x_wr_data, d5_w_wr_data} = '0;
    reset_model();
    tick();
    tick();
    chk("reset valid", 128'(rd_valid), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset done", 128'(done), 128'(0));
    chk("reset drop", 128'(w_wr_drop), 128'(0));
    chk("reset row", 128'(rd_row), 128'(0));
    chk("reset xout", x_out, 128'(0));
    rst = 1'b1;
    tick();

    // 1: default weights, zero X
    run_stream("t1");

    // 2: shadow write then swap in IDLE
    x_wr_en = 1'b1;
    for (int a = 0; a < N; a++) begin
      x_wr_addr = 2'(a);
      x_wr_data = x1[a];
      tick();
      xs[a] = x1[a];
    end
    x_wr_en = 1'b0;
    chk("t2 pre-swap xout", x_out, xvec());
    x_swap = 1'b1;
    tick();
    x_swap = 1'b0;
    xm = xs;
    xs = '{default: 32'h0};
    chk("t2 post-swap xout", x_out, xvec());
    x_wr_en = 1'b1;
    for (int a = 0; a < N; a++) begin
      x_wr_addr = 2'(a);
      x_wr_data = x2[a];
      tick();
      xs[a] = x2[a];
    end
    x_wr_en = 1'b0;
    chk("t2 shadow hidden", x_out, xvec());
    run_stream("t2");

    // 3: stall pattern from the table
    rd_start = 1'b1;
    rd_ready = 1'b0;
    tick();
    rd_start = 1'b0;
    xfers = 0;
    chk("t3 first valid", 128'(rd_valid), 128'(1));
    chk("t3 first row", 128'(rd_row), 128'(0));
    for (int i = 0; i < 11; i++) begin
      rd_ready = sv[i].ready;
      if (rd_ready && rd_valid) xfers++;
      tick();
      chk($sformatf("t3 v%0d valid", i), 128'(rd_valid), 128'(sv[i].v));
      chk($sformatf("t3 v%0d row", i), 128'(rd_row), 128'(sv[i].row));
      chk($sformatf("t3 v%0d last", i), 128'(rd_last), 128'(sv[i].last));
      chk($sformatf("t3 v%0d done", i), 128'(done), 128'(sv[i].dn));
      chk($sformatf("t3 v%0d busy", i), 128'(busy), 128'(sv[i].bz));
      if (sv[i].v) chk($sformatf("t3 v%0d wrow", i), w_row_out, wrow(int'(sv[i].row)));
      chk($sformatf("t3 v%0d xout", i), x_out, xvec());
    end
    chk("t3 transfers", 128'(xfers), 128'(4));

    // 4: swap requests and X write during STREAM are deferred to stream exit
    rd_start = 1'b1;
    rd_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("t4 r0 xout", x_out, xvec());
    tick();
    x_swap    = 1'b1;
    x_wr_en   = 1'b1;
    x_wr_addr = 2'd0;
    x_wr_data = 32'hdeadbeef;
    tick();
    xs[0]   = 32'hdeadbeef;
    x_wr_en = 1'b0;
    chk("t4 r2 xout", x_out, xvec());
    tick();
    x_swap = 1'b0;
    chk("t4 r3 last", 128'(rd_last), 128'(1));
    chk("t4 r3 xout", x_out, xvec());
    tick();
    xm = xs;
    xs = x1;
    chk("t4 done", 128'(done), 128'(1));
    chk("t4 new bank", x_out, xvec());
    tick();
    chk("t4 single swap", x_out, xvec());

    // 5: weight writes rejected while streaming, accepted in IDLE
    rd_start = 1'b1;
    rd_ready = 1'b0;
    tick();
    rd_start  = 1'b0;
    w_wr_en   = 1'b1;
    w_wr_row  = 2'd2;
    w_wr_col  = 2'd1;
    w_wr_data = 32'h12345678;
    tick();
    w_wr_en = 1'b0;
    chk("t5 stream drop", 128'(w_wr_drop), 128'(1));
    chk("t5 stall row", 128'(rd_row), 128'(0));
    tick();
    chk("t5 drop pulse", 128'(w_wr_drop), 128'(0));
    rd_ready = 1'b1;
    for (int r = 0; r < N; r++) begin
      chk($sformatf("t5 r%0d wrow", r), w_row_out, wrow(r));
      tick();
    end
    chk("t5 done", 128'(done), 128'(1));
    tick();
    w_wr_en   = 1'b1;
    w_wr_row  = 2'd2;
    w_wr_col  = 2'd0;
    w_wr_data = FP_ONE;
    tick();
    wm[2][0] = FP_ONE;
    chk("t5 idle no drop", 128'(w_wr_drop), 128'(0));
    w_wr_row  = 2'd0;
    w_wr_col  = 2'd3;
    w_wr_data = 32'h40a00000;
    wm[0][3]  = 32'h40a00000;
    run_stream("t5b");

    d5_w_wr_en   = 1'b1;
    d5_w_wr_row  = 3'd5;
    d5_w_wr_col  = 3'd0;
    d5_w_wr_data = 32'h11111111;
    tick();
    chk("t5 n5 row oob drop", 128'(d5_w_wr_drop), 128'(1));
    d5_w_wr_row = 3'd0;
    d5_w_wr_col = 3'd5;
    tick();
    chk("t5 n5 col oob drop", 128'(d5_w_wr_drop), 128'(1));
    d5_w_wr_row = 3'd4;
    d5_w_wr_col = 3'd4;
    tick();
    chk("t5 n5 in range", 128'(d5_w_wr_drop), 128'(0));
    d5_w_wr_en = 1'b0;
    tick();
    chk("t5 n5 idle", 128'(d5_w_wr_drop), 128'(0));

    // 6: asynchronous reset in the middle of a stream
    w_wr_en = 1'b1;
    w_wr_row = 2'd1;
    w_wr_col = 2'd1;
    w_wr_data = 32'h55555555;
    tick();
    w_wr_en  = 1'b0;
    rd_start = 1'b1;
    rd_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    tick();
    chk("t6 pre-reset row", 128'(rd_row), 128'(2));
    #2;
    rst = 1'b0;
    #1;
    reset_model();
    chk("t6 async valid", 128'(rd_valid), 128'(0));
    chk("t6 async busy", 128'(busy), 128'(0));
    chk("t6 async row", 128'(rd_row), 128'(0));
    chk("t6 async xout", x_out, xvec());
    chk("t6 async wrow", w_row_out, wrow(0));
    tick();
    chk("t6 no done in reset", 128'(done), 128'(0));
    rst = 1'b1;
    tick();
    chk("t6 no done after", 128'(done), 128'(0));
    chk("t6 idle valid", 128'(rd_valid), 128'(0));
    run_stream("t6");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
